// File: rtl/serial_tx_shift.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over valid/ready and
// emits it one bit per clock on tx_data qualified by tx_enable, gapless back-to-back.
module serial_tx_shift #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             tx_data,
  output logic             tx_enable,
  output logic             tx_last,
  output logic             busy
);

  localparam int unsigned   CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             tx_data_q;
  logic             tx_enable_q;
  logic             tx_last_q;
  logic             at_last;
  logic             accept;

  // Bit at transmit position idx, honouring the configured bit order.
  function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] idx);
    if (MSB_FIRST) return w[LAST_IDX - idx];
    else           return w[idx];
  endfunction

  assign cnt_d      = cnt_q + CW'(1);
  assign at_last    = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign load_ready = !rst && ((state_q == IDLE) || at_last);
  assign accept     = load_valid && load_ready;
  assign busy       = (state_q == SHIFT);

  assign tx_data    = tx_data_q;
  assign tx_enable  = tx_enable_q;
  assign tx_last    = tx_last_q;

  // Outputs are precomputed one edge ahead so they line up with the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      tx_data_q   <= 1'b0;
      tx_enable_q <= 1'b0;
      tx_last_q   <= 1'b0;
    end else if (accept) begin
      state_q     <= SHIFT;
      shreg_q     <= load_data;
      cnt_q       <= '0;
      tx_data_q   <= pick(load_data, '0);
      tx_enable_q <= 1'b1;
      tx_last_q   <= 1'b0;
    end else if (state_q == SHIFT) begin
      if (at_last) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        tx_data_q   <= 1'b0;
        tx_enable_q <= 1'b0;
        tx_last_q   <= 1'b0;
      end else begin
        cnt_q       <= cnt_d;
        tx_data_q   <= pick(shreg_q, cnt_d);
        tx_enable_q <= 1'b1;
        tx_last_q   <= (cnt_d == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_shift.sv
// Bench for serial_tx_shift: an LSB-first and an MSB-first instance checked every
// cycle against a bit-queue model, plus literal expectations for directed words.
module tb_serial_tx_shift;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vl = 1'b0, vm = 1'b0;
  logic [W-1:0] dl = '0, dm = '0;
  logic         rdy_l, txd_l, en_l, last_l, busy_l;
  logic         rdy_m, txd_m, en_m, last_m, busy_m;

  int total = 0;
  int bad   = 0;

  serial_tx_shift #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(vl), .load_ready(rdy_l), .load_data(dl),
    .tx_data(txd_l), .tx_enable(en_l), .tx_last(last_l), .busy(busy_l)
  );

  serial_tx_shift #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load_valid(vm), .load_ready(rdy_m), .load_data(dm),
    .tx_data(txd_m), .tx_enable(en_m), .tx_last(last_m), .busy(busy_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance owes a queue of {last, bit} still to be emitted after the current one.
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic e0 = 1'b0, d0 = 1'b0, l0 = 1'b0;
  logic e1 = 1'b0, d1 = 1'b0, l1 = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q0.delete(); q1.delete();
      {e0, d0, l0} = 3'b000;
      {e1, d1, l1} = 3'b000;
    end else begin
      if (vl && q0.size() == 0)
        for (int i = 0; i < W; i++) q0.push_back({(i == W - 1), dl[i]});
      if (vm && q1.size() == 0)
        for (int i = 0; i < W; i++) q1.push_back({(i == W - 1), dm[W-1-i]});
      if (q0.size() != 0) begin {l0, d0} = q0.pop_front(); e0 = 1'b1; end
      else {e0, d0, l0} = 3'b000;
      if (q1.size() != 0) begin {l1, d1} = q1.pop_front(); e1 = 1'b1; end
      else {e1, d1, l1} = 3'b000;
    end
  end

  // Every-cycle compare, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("lsb_en",    32'(en_l),   32'(e0));
    chk("lsb_data",  32'(txd_l),  32'(d0));
    chk("lsb_last",  32'(last_l), 32'(l0));
    chk("lsb_busy",  32'(busy_l), 32'(e0));
    chk("lsb_ready", 32'(rdy_l),  32'(!rst && q0.size() == 0));
    chk("msb_en",    32'(en_m),   32'(e1));
    chk("msb_data",  32'(txd_m),  32'(d1));
    chk("msb_last",  32'(last_m), 32'(l1));
    chk("msb_busy",  32'(busy_m), 32'(e1));
    chk("msb_ready", 32'(rdy_m),  32'(!rst && q1.size() == 0));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input int k, output logic e, output logic d, output logic l,
                    output logic r);
    if (k == 0) begin e = en_l; d = txd_l; l = last_l; r = rdy_l; end
    else        begin e = en_m; d = txd_m; l = last_m; r = rdy_m; end
  endtask

  // Collect n cycles of one instance; first bit ends up most significant.
  task automatic grab(input int k, input int n, output logic [15:0] bits,
                      output logic [15:0] lasts, output int ens);
    logic e, d, l, r;
    bits = '0; lasts = '0; ens = 0;
    for (int i = 0; i < n; i++) begin
      rd(k, e, d, l, r);
      bits  = {bits[14:0], d & e};
      lasts = {lasts[14:0], l};
      if (e) ens++;
      tick();
    end
  endtask

  initial begin
    logic [15:0] bits, lasts, rdys;
    logic e, d, l, r;
    int ens;

    // Reset with load_valid already high: must not be taken until rst falls.
    vl = 1'b1; dl = 8'hA5;
    tick(); tick();
    chk("rst_ready_low", 32'(rdy_l), 32'd0);
    chk("rst_en_low",    32'(en_l),  32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(rdy_l), 32'd1);

    // Single word LSB-first.
    tick();
    vl = 1'b0;
    grab(0, 8, bits, lasts, ens);
    chk("t2_bits",  32'(bits[7:0]),  32'hA5);
    chk("t2_lasts", 32'(lasts[7:0]), 32'h01);
    chk("t2_ens",   32'(ens),        32'd8);
    chk("t2_idle",  32'(en_l),       32'd0);

    // MSB-first: palindrome then 0x3C.
    vm = 1'b1; dm = 8'hA5;
    tick();
    vm = 1'b0;
    grab(1, 8, bits, lasts, ens);
    chk("t3_a5", 32'(bits[7:0]), 32'hA5);
    vm = 1'b1; dm = 8'h3C;
    tick();
    vm = 1'b0;
    grab(1, 8, bits, lasts, ens);
    chk("t3_3c",   32'(bits[7:0]),  32'h3C);
    chk("t3_last", 32'(lasts[7:0]), 32'h01);

    // Back-to-back with valid held.
    vl = 1'b1; dl = 8'hA5;
    tick();
    dl = 8'h3C;
    bits = '0; lasts = '0; rdys = '0; ens = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) vl = 1'b0;
      rd(0, e, d, l, r);
      bits = {bits[14:0], d}; lasts = {lasts[14:0], l}; rdys = {rdys[14:0], r};
      if (e) ens++;
      tick();
    end
    chk("t4_bits",  32'(bits),  32'hA53C);
    chk("t4_lasts", 32'(lasts), 32'h0101);
    chk("t4_ready", 32'(rdys),  32'h0101);
    chk("t4_ens",   32'(ens),   32'd16);
    chk("t4_idle",  32'(en_l),  32'd0);

    // Valid pulsed mid-word is dropped.
    vl = 1'b1; dl = 8'h00;
    tick();
    vl = 1'b0;
    bits = '0; ens = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin vl = 1'b1; dl = 8'hFF; end
      else if (i == 4) vl = 1'b0;
      rd(0, e, d, l, r);
      bits = {bits[14:0], d};
      if (e) ens++;
      tick();
    end
    chk("t5_bits", 32'(bits[7:0]), 32'h00);
    chk("t5_ens",  32'(ens),       32'd8);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_ff", 32'(en_l), 32'd0);
      tick();
    end

    // Reset mid-word, then a clean word.
    vl = 1'b1; dl = 8'hF0;
    tick();
    vl = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_midword_en", 32'(en_l), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_en",    32'(en_l),   32'd0);
    chk("t6_rst_data",  32'(txd_l),  32'd0);
    chk("t6_rst_last",  32'(last_l), 32'd0);
    chk("t6_rst_busy",  32'(busy_l), 32'd0);
    chk("t6_rst_ready", 32'(rdy_l),  32'd0);
    tick();
    rst = 1'b0;
    vl = 1'b1; dl = 8'h81;
    #1;
    chk("t6_ready", 32'(rdy_l), 32'd1);
    tick();
    vl = 1'b0;
    grab(0, 8, bits, lasts, ens);
    chk("t6_bits",  32'(bits[7:0]),  32'h81);
    chk("t6_lasts", 32'(lasts[7:0]), 32'h01);
    chk("t6_ens",   32'(ens),        32'd8);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
